// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB transfers with one response each.
module apb_cmd_master #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned RDATA_LAG = 1
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        cmd_vld_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] paddr_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  output logic        busy_o
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_LAG    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic          pwrite_q, pwrite_d, err_q, err_d;
  logic          psel_q, penable_q, rsp_vld_q, busy_q;
  logic          expired;

  // Counter value after this cycle's wait reaches the limit; pready still takes precedence.
  assign expired = (TIMEOUT != 0) && (({1'b0, cnt_q} + 1'b1) >= (CW + 1)'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (cmd_vld_i) begin
        state_d  = S_SETUP;
        paddr_d  = cmd_addr_i;
        pwrite_d = cmd_write_i;
        pwdata_d = cmd_write_i ? cmd_wdata_i : 32'd0;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: if (pready_i) begin
        if (pwrite_q) state_d = S_RESP;
        else if (RDATA_LAG == 0) begin
          rdata_d = prdata_i;
          state_d = S_RESP;
        end else state_d = S_LAG;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (expired) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      S_LAG: begin
        rdata_d = prdata_i;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_rdy_i) begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      paddr_q   <= 32'd0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_q <= state_d == S_ACCESS;
      rsp_vld_q <= state_d == S_RESP;
      busy_q    <= state_d != S_IDLE;
    end
  end

  assign cmd_rdy_o   = (state_q == S_IDLE) && !prst_i;
  assign rsp_vld_o   = rsp_vld_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwdata_o    = pwdata_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed plus random commands against a register-file slave and a scoreboard memory.
module tb_apb_cmd_master;
  logic        clk = 1'b0;
  logic        prst, cmd_vld, cmd_rdy, cmd_write, rsp_vld, rsp_rdy, rsp_err;
  logic        pwrite, psel, penable, pready, busy;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  logic        mem_clr;
  int          wait_n, acc_cnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(.TIMEOUT(4), .RDATA_LAG(1)) dut (
    .pclk_i(clk), .prst_i(prst), .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .busy_o(busy)
  );

  // Slave: inserts wait_n wait states, registers read data at the completing ACCESS edge.
  assign pready = psel && penable && (acc_cnt >= wait_n);
  always @(posedge clk) begin
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
    if (mem_clr) for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
    else if (psel && penable && pready && pwrite) mem[paddr[4:2]] <= pwdata;
    if (psel && penable && pready && !pwrite) prdata <= mem[paddr[4:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic w, input logic [2:0] idx, input logic [31:0] d,
                        input int waits, input int stall);
    logic [31:0] a, exp_rd;
    logic to;
    int lat, acc;
    a = {27'd0, idx, 2'b00};
    to = waits >= 4;
    exp_rd = (w || to) ? 32'd0 : ref_mem[idx];
    @(negedge clk);
    wait_n = waits;
    cmd_vld = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
    chk("rsp_vld_idle", {31'd0, rsp_vld}, 32'd0);
    @(posedge clk);
    acc = 0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      cmd_vld = 1'b0;
      if (psel) begin
        chk("paddr_stable", paddr, a);
        chk("pwrite_stable", {31'd0, pwrite}, {31'd0, w});
        chk("pwdata_stable", pwdata, w ? d : 32'd0);
        acc += int'(penable);
      end
      if (rsp_vld) break;
    end
    chk("rsp_latency", lat, to ? 6 : (w ? 3 : 4) + waits);
    chk("access_cycles", acc, to ? 4 : waits + 1);
    chk("rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, to});
    chk("busy_resp", {31'd0, busy}, 32'd1);
    if (stall > 0) begin
      rsp_rdy = 1'b0;
      cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = 32'd0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        chk("stall_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("stall_rdata", rsp_rdata, exp_rd);
        chk("stall_err", {31'd0, rsp_err}, {31'd0, to});
        chk("stall_psel", {31'd0, psel}, 32'd0);
      end
      rsp_rdy = 1'b1;
    end
    @(posedge clk);
    if (w && !to) ref_mem[idx] = d;
  endtask

  initial begin
    prst = 1'b1; mem_clr = 1'b1; rsp_rdy = 1'b1; wait_n = 0;
    cmd_vld = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    prst = 1'b0; mem_clr = 1'b0;

    do_cmd(1'b1, 3'd5, 32'h0000_0401, 0, 0);
    do_cmd(1'b1, 3'd4, 32'hDEAD_BEEF, 0, 0);
    do_cmd(1'b0, 3'd4, 32'd0, 0, 0);
    do_cmd(1'b1, 3'd3, 32'hA5A5_0C0C, 3, 0);
    do_cmd(1'b1, 3'd2, 32'h0000_1234, 99, 0);
    do_cmd(1'b0, 3'd2, 32'd0, 99, 0);
    do_cmd(1'b0, 3'd5, 32'd0, 0, 0);
    do_cmd(1'b1, 3'd0, 32'h0000_CAFE, 1, 5);
    do_cmd(1'b0, 3'd3, 32'd0, 0, 0);

    // Reset in the middle of an ACCESS wait: transfer is dropped with no response.
    @(negedge clk);
    wait_n = 2; cmd_vld = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    @(negedge clk);
    chk("mid_penable", {31'd0, penable}, 32'd1);
    prst = 1'b1;
    @(negedge clk);
    chk("mrst_psel", {31'd0, psel}, 32'd0);
    chk("mrst_penable", {31'd0, penable}, 32'd0);
    chk("mrst_pwrite", {31'd0, pwrite}, 32'd0);
    chk("mrst_paddr", paddr, 32'd0);
    chk("mrst_pwdata", pwdata, 32'd0);
    chk("mrst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    prst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      chk("post_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    end
    do_cmd(1'b0, 3'd1, 32'd0, 0, 0);

    for (int n = 0; n < 40; n++)
      do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), $urandom,
             int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0) ? 2 : 0);
    for (int i = 0; i < 6; i++) do_cmd(1'b0, 3'(i), 32'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
